playback_sequencer: RTL and testbench
=====================================

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter TICK_MAX, default 12500000; HOLD duration per step in clock cycles (0.25 s at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter LAST_ADDR, default 8'h80; final memory address played.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begins playback from address 0.
REQ-006 SHALL have port stop  input  1  level; aborts playback.
REQ-007 SHALL have port pause  input  1  level; freezes step timer.
REQ-008 SHALL have port loop  input  1  level; wrap to address 0 after LAST_ADDR instead of finishing.
REQ-009 SHALL have port rec_done  input  1  recording memory complete and readable.
REQ-010 SHALL have port rd_data  input  4  recorded key bits; valid one cycle after rd_addr is presented.
REQ-011 SHALL have port rd_addr  output  8  registered read address to recording memory.
REQ-012 SHALL have port note  output  4  registered key bits currently played.
REQ-013 SHALL have port note_valid  output  1  one-cycle pulse when note is updated.
REQ-014 SHALL have port playing  output  1  high in ISSUE, CAPTURE and HOLD.
REQ-015 SHALL have port finished  output  1  high only in DONE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD, DONE.
REQ-017 IDLE: when start=1, stop=0 and rec_done=1 -> ISSUE next cycle with rd_addr=0, tick counter=0; start with rec_done=0 ignored.
REQ-018 ISSUE: one cycle, rd_addr stable -> CAPTURE.
REQ-019 CAPTURE: note <= rd_data, note_valid=1 for exactly this cycle -> HOLD with tick counter=0.
REQ-020 HOLD: tick counter increments each cycle with pause=0; holds value with pause=1.
REQ-021 HOLD, counter==TICK_MAX-1 and pause=0, rd_addr!=LAST_ADDR: rd_addr <= rd_addr+1, -> ISSUE.
REQ-022 HOLD, counter==TICK_MAX-1 and pause=0, rd_addr==LAST_ADDR: loop=1 -> rd_addr<=0, ISSUE; loop=0 -> DONE.
REQ-023 Unpaused step period SHALL be exactly TICK_MAX+2 cycles between consecutive note_valid pulses.
REQ-024 Tick counter SHALL be 24 bits; rd_addr increment SHALL be 8-bit, never exceeding LAST_ADDR.
REQ-025 DONE: note=0, finished=1, rd_addr holds LAST_ADDR; start=1 (rec_done=1, stop=0) -> ISSUE at address 0.
REQ-026 stop=1 in any non-IDLE state SHALL force IDLE next cycle: note=0, rd_addr=0, counter=0.
REQ-027 rec_done falling while playing SHALL abort identically to stop.
REQ-028 Priority SHALL be reset > stop/rec_done abort > start > pause.
REQ-029 pause SHALL affect HOLD only; ISSUE and CAPTURE complete regardless.
REQ-030 start held high in ISSUE/CAPTURE/HOLD SHALL have no effect (no restart).

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, rd_addr=0, note=0, note_valid=0, playing=0, finished=0, counter=0.
REQ-032 Reset asserted mid-playback SHALL take effect on that edge regardless of other inputs; no note_valid pulse follows.

Verification (TICK_MAX=4, LAST_ADDR=3, memory[i]=i+1)
REQ-033 Basic play: rec_done=1, start pulse -> note 1,2,3,4 with note_valid every 6 cycles, rd_addr 0..3, then finished=1, note=0, playing=0.
REQ-034 Loop: loop=1 -> after note=4, rd_addr returns to 0 and note=1 appears 6 cycles later; finished stays 0.
REQ-035 Pause: pause=1 for 10 cycles during HOLD of note 2 -> next note_valid delayed by exactly 10 cycles; note stays 2.
REQ-036 Abort: stop=1 during HOLD of note 3, or rec_done dropped -> IDLE next cycle, note=0, rd_addr=0, no further note_valid.
REQ-037 Gating: start with rec_done=0 -> remains IDLE, playing=0; reset mid-HOLD -> all outputs 0 next cycle.
REQ-038 Restart: start in DONE -> note=1 after 2 cycles, finished deasserts on the cycle ISSUE is entered.

Source files
------------

// File: rtl/playback_sequencer.sv
// Replays recorded key bits from memory, one step per TICK_MAX+2 clocks.
// Supports start/stop/pause/loop and aborts when the recording goes away.
module playback_sequencer #(
   parameter int          TICK_MAX  = 12500000,
   parameter logic [7:0]  LAST_ADDR = 8'h80
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       loop,
   input  logic       rec_done,
   input  logic [3:0] rd_data,
   output logic [7:0] rd_addr,
   output logic [3:0] note,
   output logic       note_valid,
   output logic       playing,
   output logic       finished
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      HOLD,
      DONE
   } state_t;

   localparam logic [23:0] TICK_LAST = 24'(TICK_MAX - 1);

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [23:0] cnt_q, cnt_d;
   logic [3:0]  note_q, note_d;
   logic        nv_q, nv_d;

   logic active;
   logic abort;
   logic go;
   logic tick_end;
   logic at_last;

   assign active   = (state_q == ISSUE) || (state_q == CAPTURE)
                  || (state_q == HOLD);
   assign abort    = (state_q != IDLE) && (stop || (active && !rec_done));
   assign go       = start && !stop && rec_done;
   assign tick_end = (cnt_q == TICK_LAST) && !pause;
   assign at_last  = (addr_q == LAST_ADDR);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         note_q  <= '0;
         nv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         nv_q    <= nv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (go) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD: begin
               if (tick_end) begin
                  state_d = (!at_last || loop) ? ISSUE : DONE;
               end
            end
            DONE:    if (go) state_d = ISSUE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      note_d = note_q;
      nv_d   = 1'b0;
      if (abort) begin
         addr_d = '0;
         cnt_d  = '0;
         note_d = '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (go) begin
                  addr_d = '0;
                  cnt_d  = '0;
               end
            end
            CAPTURE: begin
               note_d = rd_data;
               nv_d   = 1'b1;
               cnt_d  = '0;
            end
            HOLD: begin
               if (tick_end) begin
                  cnt_d = '0;
                  if (!at_last) begin
                     addr_d = addr_q + 8'd1;
                  end else if (loop) begin
                     addr_d = '0;
                  end else begin
                     note_d = '0;
                  end
               end else if (!pause) begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      playing  = active;
      finished = (state_q == DONE);
   end

   assign rd_addr    = addr_q;
   assign note       = note_q;
   assign note_valid = nv_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer with TICK_MAX=4, LAST_ADDR=3.
// A monitor checks every note_valid pulse against queued notes and gaps.
module tb_playback_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, stop, pause, loop, rec_done;
   logic [3:0] rd_data;
   logic [7:0] rd_addr;
   logic [3:0] note;
   logic       note_valid, playing, finished;

   typedef struct {
      logic [3:0] n;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   last   = 0;

   playback_sequencer #(.TICK_MAX(4), .LAST_ADDR(8'd3)) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .loop      (loop),
      .rec_done  (rec_done),
      .rd_data   (rd_data),
      .rd_addr   (rd_addr),
      .note      (note),
      .note_valid(note_valid),
      .playing   (playing),
      .finished  (finished)
   );

   always #5 clk = ~clk;

   // memory[i] = i+1, one cycle read latency
   always @(posedge clk) begin
      rd_data <= rd_addr[3:0] + 4'd1;
      cyc     <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [3:0] n, input int gap);
      exp_t e;
      e.n   = n;
      e.gap = gap;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (note_valid) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: got note %0d, expected none",
                     note);
         end else begin
            e = sb.pop_front();
            check("note", int'(note), int'(e.n));
            if (e.gap != 0) check("gap", cyc - last, e.gap);
         end
         last = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_size(input int n, input int budget);
      int k = 0;
      while (sb.size() > n && k < budget) begin
         tick(1);
         k++;
      end
      check("sb_wait", sb.size(), n);
   endtask

   task automatic wait_fin(input int budget);
      int k = 0;
      while (!finished && k < budget) begin
         tick(1);
         k++;
      end
      check("finished", int'(finished), 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_addr"}, int'(rd_addr), 0);
      check({tag, "_note"}, int'(note), 0);
      check({tag, "_play"}, int'(playing), 0);
      check({tag, "_fin"}, int'(finished), 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      pause = 1'b0;
      loop = 1'b0;
      rec_done = 1'b0;
      tick(2);
      chk_zero("rst");
      check("rst_nv", int'(note_valid), 0);
      reset = 1'b0;
      tick(1);

      // basic play
      rec_done = 1'b1;
      push(4'd1, 0);
      push(4'd2, 6);
      push(4'd3, 6);
      push(4'd4, 6);
      pulse_start();
      wait_fin(100);
      check("done_note", int'(note), 0);
      check("done_play", int'(playing), 0);
      check("done_addr", int'(rd_addr), 3);
      check("sb_empty", sb.size(), 0);

      // restart from DONE, start held high through playback
      push(4'd1, 0);
      push(4'd2, 6);
      push(4'd3, 6);
      push(4'd4, 6);
      start = 1'b1;
      tick(1);
      check("rs_fin", int'(finished), 0);
      check("rs_play", int'(playing), 1);
      tick(2);
      check("rs_nv", int'(note_valid), 1);
      check("rs_note", int'(note), 1);
      tick(8);
      start = 1'b0;
      wait_fin(100);

      // loop, then drop rec_done in HOLD of note 2
      loop = 1'b1;
      push(4'd1, 0);
      push(4'd2, 6);
      push(4'd3, 6);
      push(4'd4, 6);
      push(4'd1, 6);
      push(4'd2, 6);
      pulse_start();
      wait_size(0, 100);
      check("lp_fin", int'(finished), 0);
      check("lp_addr", int'(rd_addr), 1);
      rec_done = 1'b0;
      tick(1);
      chk_zero("rd_abort");
      rec_done = 1'b1;
      loop = 1'b0;
      tick(20);
      check("rd_idle", int'(playing), 0);

      // stop during HOLD of note 3
      push(4'd1, 0);
      push(4'd2, 6);
      push(4'd3, 6);
      pulse_start();
      wait_size(0, 100);
      stop = 1'b1;
      tick(1);
      chk_zero("stop");
      stop = 1'b0;
      tick(20);

      // pause 10 cycles in HOLD of note 2
      push(4'd1, 0);
      push(4'd2, 6);
      push(4'd3, 16);
      push(4'd4, 6);
      pulse_start();
      wait_size(2, 100);
      pause = 1'b1;
      tick(5);
      check("ps_note", int'(note), 2);
      check("ps_play", int'(playing), 1);
      tick(5);
      pause = 1'b0;
      wait_fin(100);

      // start gated by rec_done
      rec_done = 1'b0;
      start = 1'b1;
      tick(5);
      check("gate_play", int'(playing), 0);
      check("gate_fin", int'(finished), 1);
      start = 1'b0;
      rec_done = 1'b1;
      tick(1);

      // reset mid-HOLD
      push(4'd1, 0);
      push(4'd2, 6);
      pulse_start();
      wait_size(0, 100);
      tick(2);
      reset = 1'b1;
      start = 1'b1;
      tick(1);
      chk_zero("mid_rst");
      check("mid_rst_nv", int'(note_valid), 0);
      reset = 1'b0;
      start = 1'b0;
      tick(20);
      check("end_sb", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

endmodule
